// File: rtl/ff_reg_univ.sv
// ff_reg_univ: n-bit universal register (hold/load/toggle/JK/shift/modulo count)
// Ports:
//   clk        rising-edge clock
//   res_n      asynchronous active-low reset
//   clr        synchronous clear to RESET_VAL, beats en and mode
//   en         clock enable; when low q and sout hold and wrap drops
//   mode[2:0]  000 hold, 001 load, 010 toggle, 011 JK, 100 SHL, 101 SHR, 110 up, 111 down
//   din        load data / toggle mask / J vector
//   kin        K vector for JK mode
//   sin        serial input for shifts
//   q          register contents
//   sout       bit shifted out by the most recent shift
//   wrap       high for one cycle after a count wrapped
module ff_reg_univ #(
  parameter int WIDTH = 8,
  parameter longint MODULUS = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             clr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] kin,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             wrap
);
  // Largest count value, M-1; MODULUS of 0 means the full 2^WIDTH range.
  localparam logic [WIDTH-1:0] TOP = (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d;
  logic sout_q, sout_d, wrap_q, wrap_d;
  always_comb begin
    q_d = q_q;
    sout_d = sout_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = RESET_VAL;
      sout_d = 1'b0;
    end else if (en) begin
      case (mode)
        3'b000: q_d = q_q;
        3'b001: q_d = din;
        3'b010: q_d = q_q ^ din;
        // JK characteristic equation: Q+ = J & ~Q | ~K & Q
        3'b011: q_d = (din & ~q_q) | (~kin & q_q);
        3'b100: begin
          q_d = {q_q[WIDTH-2:0], sin};
          sout_d = q_q[WIDTH-1];
        end
        3'b101: begin
          q_d = {sin, q_q[WIDTH-1:1]};
          sout_d = q_q[0];
        end
        // Values above TOP (only reachable by load) wrap to zero like TOP itself.
        3'b110: begin
          wrap_d = q_q >= TOP;
          q_d = wrap_d ? '0 : q_q + WIDTH'(1);
        end
        // Out-of-range values snap to TOP without flagging a wrap.
        3'b111: begin
          wrap_d = q_q == '0;
          q_d = (wrap_d || q_q > TOP) ? TOP : q_q - WIDTH'(1);
        end
        default: q_d = 'x;
      endcase
    end
  end
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q_q <= RESET_VAL;
      sout_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      q_q <= q_d;
      sout_q <= sout_d;
      wrap_q <= wrap_d;
    end
  end
  assign q = q_q;
  assign sout = sout_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_ff_reg_univ.sv
// tb_ff_reg_univ: scoreboard bench for ff_reg_univ in 4-bit mod-10 and 8-bit full-range builds
module tb_ff_reg_univ;
  typedef struct {
    bit          d8;
    string       name;
    logic [7:0]  q;
    logic        wrap;
    logic        sout;
  } exp_t;
  logic clk = 0, res_n = 0;
  logic clr4 = 0, en4 = 0, sin4 = 0, clr8 = 0, en8 = 0, sin8 = 0;
  logic [2:0] mode4 = 0, mode8 = 0;
  logic [3:0] din4 = 0, kin4 = 0, q4;
  logic [7:0] din8 = 0, kin8 = 0, q8;
  logic sout4, wrap4, sout8, wrap8;
  exp_t sb[$];
  int tests = 0, fails = 0;
  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, TOG = 3'b010, JK = 3'b011;
  localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, UP = 3'b110, DN = 3'b111;
  always #5 clk = ~clk;
  ff_reg_univ #(.WIDTH(4), .MODULUS(10), .RESET_VAL(4'h0)) u4 (
    .clk(clk), .res_n(res_n), .clr(clr4), .en(en4), .mode(mode4), .din(din4), .kin(kin4),
    .sin(sin4), .q(q4), .sout(sout4), .wrap(wrap4)
  );
  ff_reg_univ #(.WIDTH(8), .MODULUS(0), .RESET_VAL(8'h5A)) u8 (
    .clk(clk), .res_n(res_n), .clr(clr8), .en(en8), .mode(mode8), .din(din8), .kin(kin8),
    .sin(sin8), .q(q8), .sout(sout8), .wrap(wrap8)
  );
  initial forever begin
    @(posedge clk or negedge res_n);
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      logic [7:0] aq;
      logic aw, as;
      e = sb.pop_front();
      aq = e.d8 ? q8 : {4'h0, q4};
      aw = e.d8 ? wrap8 : wrap4;
      as = e.d8 ? sout8 : sout4;
      tests++;
      if (aq !== e.q || aw !== e.wrap || as !== e.sout) begin
        fails++;
        $display("FAIL %s: got q=%h wrap=%b sout=%b, expected q=%h wrap=%b sout=%b",
                 e.name, aq, aw, as, e.q, e.wrap, e.sout);
      end
    end
  end
  task automatic step(input bit d8, input logic c, input logic e, input logic [2:0] m,
                      input logic [7:0] di, input logic [7:0] ki, input logic s, input string nm,
                      input logic [7:0] xq, input logic xw, input logic xs);
    @(negedge clk);
    if (d8) begin
      clr8 = c; en8 = e; mode8 = m; din8 = di; kin8 = ki; sin8 = s; clr4 = 0; en4 = 0;
    end else begin
      clr4 = c; en4 = e; mode4 = m; din4 = di[3:0]; kin4 = ki[3:0]; sin4 = s; clr8 = 0; en8 = 0;
    end
    sb.push_back('{d8, nm, xq, xw, xs});
  endtask
  initial begin
    sb.push_back('{1'b0, "reset4", 8'h00, 1'b0, 1'b0});
    sb.push_back('{1'b1, "reset8", 8'h5A, 1'b0, 1'b0});
    @(negedge clk);
    res_n = 1;
    for (int i = 1; i <= 11; i++)
      step(0, 0, 1, UP, 0, 0, 0, $sformatf("up%0d", i), 8'(i % 10), i == 10, 0);
    step(0, 0, 1, LOAD, 8'h0C, 0, 0, "load_c", 8'h0C, 0, 0);
    step(0, 0, 1, DN, 0, 0, 0, "dn_oor", 8'h09, 0, 0);
    step(0, 0, 1, DN, 0, 0, 0, "dn_8", 8'h08, 0, 0);
    step(0, 0, 1, DN, 0, 0, 0, "dn_7", 8'h07, 0, 0);
    step(0, 0, 1, LOAD, 8'h00, 0, 0, "load_0", 8'h00, 0, 0);
    step(0, 0, 1, DN, 0, 0, 0, "dn_wrap", 8'h09, 1, 0);
    step(0, 0, 1, UP, 0, 0, 0, "up_wrap", 8'h00, 1, 0);
    step(0, 0, 1, LOAD, 8'h0C, 0, 0, "load_c2", 8'h0C, 0, 0);
    step(0, 0, 1, UP, 0, 0, 0, "up_oor", 8'h00, 1, 0);
    step(0, 0, 0, UP, 0, 0, 0, "en0_up", 8'h00, 0, 0);
    step(0, 0, 1, LOAD, 8'h06, 0, 0, "load_6", 8'h06, 0, 0);
    step(0, 0, 1, UP, 0, 0, 0, "up_7", 8'h07, 0, 0);
    @(negedge clk);
    en4 = 0;
    #2;
    sb.push_back('{1'b0, "async_rst4", 8'h00, 1'b0, 1'b0});
    sb.push_back('{1'b1, "async_rst8", 8'h5A, 1'b0, 1'b0});
    res_n = 0;
    @(posedge clk);
    #2;
    res_n = 1;
    step(0, 0, 1, UP, 0, 0, 0, "resume1", 8'h01, 0, 0);
    step(0, 0, 1, UP, 0, 0, 0, "resume2", 8'h02, 0, 0);
    step(1, 0, 1, LOAD, 8'hA5, 0, 0, "load_a5", 8'hA5, 0, 0);
    step(1, 0, 1, SHL, 0, 0, 1, "shl1", 8'h4B, 0, 1);
    step(1, 0, 1, SHL, 0, 0, 1, "shl2", 8'h97, 0, 0);
    step(1, 0, 1, SHR, 0, 0, 0, "shr", 8'h4B, 0, 1);
    step(1, 0, 1, HOLD, 8'hFF, 0, 0, "hold", 8'h4B, 0, 1);
    step(1, 0, 1, LOAD, 8'hF0, 0, 0, "load_f0", 8'hF0, 0, 1);
    step(1, 0, 1, JK, 8'hCC, 8'hAA, 0, "jk", 8'h5C, 0, 1);
    step(1, 0, 1, LOAD, 8'h3C, 0, 0, "load_3c", 8'h3C, 0, 1);
    step(1, 0, 1, TOG, 8'h0F, 0, 0, "toggle", 8'h33, 0, 1);
    step(1, 1, 0, LOAD, 8'hFF, 0, 0, "clr_en0", 8'h5A, 0, 0);
    step(1, 0, 1, LOAD, 8'hFF, 0, 0, "load_ff", 8'hFF, 0, 0);
    step(1, 0, 1, UP, 0, 0, 0, "up_full", 8'h00, 1, 0);
    step(1, 0, 1, DN, 0, 0, 0, "dn_full", 8'hFF, 1, 0);
    step(1, 0, 0, UP, 0, 0, 0, "en0_up8", 8'hFF, 0, 0);
    step(1, 0, 1, SHR, 0, 0, 1, "shr_ff", 8'hFF, 0, 1);
    step(1, 1, 1, SHL, 0, 0, 0, "clr_shl", 8'h5A, 0, 0);
    @(negedge clk);
    en8 = 0;
    clr8 = 0;
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
